// File: rtl/m_memarb_pkg.sv
// Shared processor constants for the two-port memory arbiter: default
// memory geometry, port indices and the round-robin tie-break helper.
package m_memarb_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    localparam logic P_DATA  = 1'b0;
    localparam logic P_FETCH = 1'b1;

    // On a tie under round-robin the port that did not win last time wins now.
    function automatic logic rr_winner(input logic last);
        return ~last;
    endfunction

endpackage

// File: rtl/m_starve_cnt.sv
// Saturating up-counter tracking how many consecutive cycles the fetch port
// has been kept waiting. Clear has priority over increment.
module m_starve_cnt #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         w_clk,
    input  logic         w_rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count waiting cycles, stopping at MAX until the port is served or idles.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/m_memarb.sv
// Two-port single-memory arbiter. Port 0 is the data (MEM stage) side, port 1
// the fetch/loader side. The grant is combinational so an uncontended request
// is served in the cycle it appears; reads return one cycle later.
module m_memarb
    import m_memarb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_rr,
    input  logic              w_req0,
    input  logic              w_we0,
    input  logic [ADDR_W-1:0] w_addr0,
    input  logic [DATA_W-1:0] w_din0,
    output logic              w_gnt0,
    output logic              w_rvld0,
    input  logic              w_req1,
    input  logic              w_we1,
    input  logic [ADDR_W-1:0] w_addr1,
    input  logic [DATA_W-1:0] w_din1,
    output logic              w_gnt1,
    output logic              w_rvld1,
    output logic [DATA_W-1:0] w_rdata,
    output logic [ADDR_W-1:0] w_maddr,
    output logic              w_mwe,
    output logic [DATA_W-1:0] w_mdin,
    input  logic [DATA_W-1:0] w_mdout,
    output logic [WAIT_W-1:0] w_wait1
);

    logic              r_last;
    logic [WAIT_W-1:0] r_wait1;
    logic              tie_win;
    logic              wait_inc;

    // Starvation counter: grows while port 1 asks and loses, clears otherwise.
    assign wait_inc = w_req1 & ~w_gnt1;

    m_starve_cnt #(
        .MAX (MAX_WAIT),
        .W   (WAIT_W)
    ) u_starve_cnt (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .inc   (wait_inc),
        .clr   (~wait_inc),
        .count (r_wait1)
    );

    assign w_wait1 = r_wait1;
    assign w_rdata = w_mdout;

    // Pick a winner and steer the memory side; reset blocks every grant.
    always_comb begin
        if (w_rr) begin
            tie_win = rr_winner(r_last);
        end else begin
            tie_win = (r_wait1 == WAIT_W'(MAX_WAIT)) ? P_FETCH : P_DATA;
        end

        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!w_rst) begin
            if (w_req0 && w_req1) begin
                w_gnt0 = (tie_win == P_DATA);
                w_gnt1 = (tie_win == P_FETCH);
            end else begin
                w_gnt0 = w_req0;
                w_gnt1 = w_req1;
            end
        end

        w_maddr = '0;
        w_mdin  = '0;
        w_mwe   = 1'b0;
        if (w_gnt0) begin
            w_maddr = w_addr0;
            w_mdin  = w_din0;
            w_mwe   = w_we0;
        end else if (w_gnt1) begin
            w_maddr = w_addr1;
            w_mdin  = w_din1;
            w_mwe   = w_we1;
        end
    end

    // Remember the last winner for round-robin and flag read returns.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_last  <= P_FETCH;
            w_rvld0 <= 1'b0;
            w_rvld1 <= 1'b0;
        end else begin
            if (w_gnt0) begin
                r_last <= P_DATA;
            end else if (w_gnt1) begin
                r_last <= P_FETCH;
            end
            w_rvld0 <= w_gnt0 & ~w_we0;
            w_rvld1 <= w_gnt1 & ~w_we1;
        end
    end

endmodule
